// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan controller with double-buffered digit frame
// Define SEG7_DIM_EN to add the bright[3:0] input that shortens each digit's lit time.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dig_en,
`ifdef SEG7_DIM_EN
  input  logic [3:0]              bright,
`endif
  output logic [4:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [4:0]    CODE_DASH  = 5'h10;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [4:0]    active  [NUM_DIGITS];
  logic [4:0]    pending [NUM_DIGITS];

  logic [IW-1:0] idx_next;
  logic          frame_wrap;
  logic          lit_entry;
  logic          lit_next;
  logic [4:0]    boundary_code0;

  assign frame_wrap = (idx == IDX_LAST);
  assign idx_next   = frame_wrap ? '0 : idx + 1'b1;

  // A load landing on the boundary cycle goes straight to the new active frame.
  assign boundary_code0 = load ? digits_in[4:0] : pending[0];

`ifdef SEG7_DIM_EN
  localparam int unsigned DIM_STEP = CLK_DIV / 16;
  logic [3:0] bright_q;

  assign lit_entry = (DIM_STEP != 32'd0);
  assign lit_next  = (32'(cnt) + 32'd1) < ((32'(bright_q) + 32'd1) * DIM_STEP);
`else
  assign lit_entry = 1'b1;
  assign lit_next  = 1'b1;
`endif

  function automatic logic [NUM_DIGITS-1:0] drive_mask(
    input logic [IW-1:0]         sel,
    input logic [NUM_DIGITS-1:0] en,
    input logic                  lit
  );
    logic [NUM_DIGITS-1:0] m;
    m = '1;
    if (lit) m[sel] = ~en[sel];
    return m;
  endfunction

  // Outputs are registered from the next state so they line up with state/cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      anode_n    <= '1;
      dec_code   <= CODE_DASH;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i]  <= CODE_DASH;
        pending[i] <= CODE_DASH;
      end
`ifdef SEG7_DIM_EN
      bright_q   <= 4'hf;
`endif
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) pending[i] <= digits_in[5*i +: 5];
      end
      case (state)
        ST_BLANK: begin
          dec_code <= active[idx];
          if (cnt == BLANK_LAST) begin
            state   <= ST_DRIVE;
            cnt     <= '0;
            anode_n <= drive_mask(idx, dig_en, lit_entry);
`ifdef SEG7_DIM_EN
            bright_q <= bright;
`endif
          end else begin
            cnt     <= cnt + 1'b1;
            anode_n <= '1;
          end
        end
        ST_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            anode_n <= '1;
            idx     <= idx_next;
            if (frame_wrap) begin
              frame_done <= 1'b1;
              dec_code   <= boundary_code0;
              for (int i = 0; i < NUM_DIGITS; i++) begin
                active[i] <= load ? digits_in[5*i +: 5] : pending[i];
              end
            end else begin
              dec_code <= active[idx_next];
            end
          end else begin
            cnt     <= cnt + 1'b1;
            anode_n <= drive_mask(idx, dig_en, lit_next);
          end
        end
        default: begin
          state   <= ST_BLANK;
          cnt     <= '0;
          anode_n <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl against a slot/frame timing model
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
`ifdef SEG7_DIM_EN
  localparam int CDIV = 16;
`else
  localparam int CDIV = 8;
`endif
  localparam int BLK   = 2;
  localparam int SLOT  = BLK + CDIV;
  localparam int FRAME = ND * SLOT;
  localparam logic [4:0] DASH = 5'h10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [5*ND-1:0] digits_in = '0;
  logic            load = 1'b0;
  logic [ND-1:0]   dig_en = '1;
  logic [4:0]      dec_code;
  logic [ND-1:0]   anode_n;
  logic            frame_done;
`ifdef SEG7_DIM_EN
  logic [3:0]      bright = 4'd15;
  logic [3:0]      bright_sel = 4'd15;
  logic [3:0]      prev_bright;
  logic [3:0]      drive_bright;
`endif

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CDIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .dig_en    (dig_en),
`ifdef SEG7_DIM_EN
    .bright    (bright),
`endif
    .dec_code  (dec_code),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            k;
    logic [4:0]    dec;
    logic [ND-1:0] an;
    logic          fd;
  } exp_t;

  exp_t            expq[$];
  int              checks = 0;
  int              failures = 0;
  int              k;
  logic [4:0]      act  [ND];
  logic [4:0]      pend [ND];
  logic            prev_load;
  logic [5*ND-1:0] prev_digits;
  logic [ND-1:0]   prev_en;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, req);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < ND; i++) begin
      act[i]  = DASH;
      pend[i] = DASH;
    end
    prev_load   = 1'b0;
    prev_digits = '0;
    prev_en     = dig_en;
  endtask

  // Expected outputs for cycle k, derived from its position in the slot/frame timeline.
  task automatic eval_push();
    exp_t e;
    int   pos, dig, d, on_len;
    if (prev_load) for (int i = 0; i < ND; i++) pend[i] = prev_digits[5*i +: 5];
    pos  = k % SLOT;
    dig  = (k / SLOT) % ND;
    e.k  = k;
    e.fd = (k % FRAME == 0) && (k > 0);
    if (e.fd) for (int i = 0; i < ND; i++) act[i] = pend[i];
    e.dec = act[dig];
    e.an  = '1;
    if (pos >= BLK) begin
      d = pos - BLK;
`ifdef SEG7_DIM_EN
      if (d == 0) drive_bright = prev_bright;
      on_len = (int'(drive_bright) + 1) * (CDIV / 16);
`else
      on_len = CDIV;
`endif
      if (prev_en[dig] && d < on_len) e.an[dig] = 1'b0;
    end
    expq.push_back(e);
    k++;
  endtask

  task automatic drive(input logic l, input logic [5*ND-1:0] dv, input logic [ND-1:0] en);
    load        = l;
    digits_in   = dv;
    dig_en      = en;
    prev_load   = l;
    prev_digits = dv;
    prev_en     = en;
`ifdef SEG7_DIM_EN
    bright      = bright_sel;
    prev_bright = bright_sel;
`endif
  endtask

  task automatic tick(input logic l, input logic [5*ND-1:0] dv, input logic [ND-1:0] en);
    @(posedge clk);
    #1;
    eval_push();
    drive(l, dv, en);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    eval_push();
    drive(1'b0, '0, 4'hf);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check($sformatf("anode_n@%0d", e.k), 32'(anode_n), 32'(e.an));
        check($sformatf("dec_code@%0d", e.k), 32'(dec_code), 32'(e.dec));
        check($sformatf("frame_done@%0d", e.k), 32'(frame_done), 32'(e.fd));
      end
    end
  end

  initial begin
    logic [5*ND-1:0] rd;
    logic [ND-1:0]   ren;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_anode_n", 32'(anode_n), 32'hf);
    check("reset_dec_code", 32'(dec_code), 32'(DASH));
    check("reset_frame_done", 32'(frame_done), 32'd0);

    release_reset();
    repeat (FRAME + 5) tick(1'b0, '0, 4'hf);

    // mid-frame load, visible only from the next boundary
    tick(1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, 4'hf);
    while (k < 3 * FRAME - 1) tick(1'b0, '0, 4'hf);

    // load on the boundary cycle itself
    tick(1'b1, {5'd9, 5'd8, 5'd7, 5'd6}, 4'hf);
    repeat (FRAME) tick(1'b0, '0, 4'hf);

    // digit 2 disabled for a whole frame
    repeat (FRAME + 3) tick(1'b0, '0, 4'b1011);

`ifdef SEG7_DIM_EN
    bright_sel = 4'd3;
    repeat (FRAME) tick(1'b0, '0, 4'hf);
    bright_sel = 4'd15;
    repeat (FRAME) tick(1'b0, '0, 4'hf);
`endif

    ren = 4'hf;
    repeat (600) begin
      rd = 20'($urandom);
      if ($urandom_range(0, 15) == 0) ren = 4'($urandom);
`ifdef SEG7_DIM_EN
      if ($urandom_range(0, 31) == 0) bright_sel = 4'($urandom);
`endif
      tick($urandom_range(0, 7) == 0, rd, ren);
    end

    // async reset during DRIVE of digit 1
`ifdef SEG7_DIM_EN
    bright_sel = 4'd15;
`endif
    while (k % FRAME != SLOT + BLK + 3) tick(1'b0, '0, 4'hf);
    @(posedge clk);
    #1;
    check("pre_reset_anode_n", 32'(anode_n), 32'hd);
    rst = 1'b1;
    #1;
    check("async_reset_anode_n", 32'(anode_n), 32'hf);
    check("async_reset_dec_code", 32'(dec_code), 32'(DASH));
    check("async_reset_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    repeat (FRAME + 4) tick(1'b0, '0, 4'hf);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
